rv_ctl: RTL and testbench

Multicycle control FSM for the `rv_dp` RISC-V datapath. Decodes `instr` (the IR output) and drives every datapath control input, one state per cycle, so the core executes RV32I ALU, load/store, branch, JAL and JALR instructions. Adds a run gate at instruction boundaries, a sticky halt on illegal opcodes, and optional performance counters. Sits beside `rv_dp` in the core top; the symbolic encodings come from `params.inc`.

---
 rtl/rv_ctl_if.sv | 36 +++
 rtl/rv_ctl.sv | 223 ++++++++++++++++++++++
 tb/tb_rv_ctl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctl_if.sv
// rv_ctl_if: control/status bundle between the rv_ctl FSM and the rv_dp datapath.
//   instr, zero      : datapath -> controller (IR contents, ALU result == 0)
//   pcsourse, pcwrite, pccen, irwrite, regwen, bff, bsel, mdrwrite : 1-bit controls
//   wbsel, immsel, asel : 2-bit controls
//   alusel           : 4-bit ALU operation select
// Modports: master = controller side, slave = datapath side.
interface rv_ctl_if #(
    parameter int DPWIDTH = 32
);
    logic [DPWIDTH-1:0] instr;
    logic               zero;
    logic               pcsourse;
    logic               pcwrite;
    logic               pccen;
    logic               irwrite;
    logic               regwen;
    logic               bff;
    logic               bsel;
    logic               mdrwrite;
    logic [1:0]         wbsel;
    logic [1:0]         immsel;
    logic [1:0]         asel;
    logic [3:0]         alusel;

    modport master (
        input  instr, zero,
        output pcsourse, pcwrite, pccen, irwrite, regwen, bff, bsel, mdrwrite,
               wbsel, immsel, asel, alusel
    );

    modport slave (
        output instr, zero,
        input  pcsourse, pcwrite, pccen, irwrite, regwen, bff, bsel, mdrwrite,
               wbsel, immsel, asel, alusel
    );
endinterface

// File: rtl/rv_ctl.sv
// rv_ctl: multicycle control FSM for the rv_dp RV32I datapath.
// Executes ALU, load/store, branch, JAL and JALR one state per cycle, gates new
// fetches with run, and parks in a sticky TRAP state on illegal opcodes.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   dp (master)   : instr/zero in, all datapath controls out (see rv_ctl_if)
//   run           : permits a new fetch, sampled only in FETCH
//   dmem_wen      : data memory write strobe
//   halt          : sticky illegal-instruction flag
//   instr_done    : one-cycle pulse in each instruction's final state
//   state         : current FSM state (debug)
//   cycle_cnt, instret_cnt : performance counters
// Optional feature macro: RV_CTL_PERF_EN enables the counters; when undefined the
// counter outputs are tied to zero and no counter flops are built.
module rv_ctl #(
    parameter int DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    rv_ctl_if.master           dp,
    input  logic               run,
    output logic               dmem_wen,
    output logic               halt,
    output logic               instr_done,
    output logic [3:0]         state,
    output logic [DPWIDTH-1:0] cycle_cnt,
    output logic [DPWIDTH-1:0] instret_cnt
);
    // Symbolic datapath encodings shared with rv_dp
    localparam logic [1:0] IMM_L = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2, IMM_J = 2'd3;
    localparam logic [1:0] ALUA_REG = 2'd0, ALUA_PCC = 2'd1;
    localparam logic       ALUB_REG = 1'b0, ALUB_IMM = 1'b1;
    localparam logic [1:0] WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2;
    localparam logic       PC_PLUS4 = 1'b0, PC_ALU = 1'b1;
    localparam logic       REGULAR_B = 1'b0;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
        S_ALU_WB = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7,
        S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
        S_JUMP_WB = 4'd12, S_TRAP = 4'd13
    } state_t;

    state_t state_reg, state_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_instr_bits;

    assign opcode = dp.instr[6:0];
    assign funct3 = dp.instr[14:12];
    assign alt    = dp.instr[30];
    assign unused_instr_bits = ^{dp.instr[DPWIDTH-1:31], dp.instr[29:15], dp.instr[11:7]};

    function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic a);
        case (f3)
            3'b000:  f3_alu = a ? ALU_SUB : ALU_ADD;
            3'b001:  f3_alu = ALU_SLL;
            3'b010:  f3_alu = ALU_SLT;
            3'b011:  f3_alu = ALU_SLTU;
            3'b100:  f3_alu = ALU_XOR;
            3'b101:  f3_alu = a ? ALU_SRA : ALU_SRL;
            3'b110:  f3_alu = ALU_OR;
            default: f3_alu = ALU_AND;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_FETCH;
        else        state_reg <= state_next;
    end

    assign dp.bff = REGULAR_B;
    assign state  = state_reg;
    assign halt   = (state_reg == S_TRAP);   // TRAP is only left through reset

    always_comb begin
        state_next   = state_reg;
        dp.pcsourse  = PC_PLUS4;
        dp.pcwrite   = 1'b0;
        dp.pccen     = 1'b0;
        dp.irwrite   = 1'b0;
        dp.regwen    = 1'b0;
        dp.bsel      = ALUB_REG;
        dp.mdrwrite  = 1'b0;
        dp.wbsel     = WB_ALUOUT;
        dp.immsel    = IMM_L;
        dp.asel      = ALUA_REG;
        dp.alusel    = ALU_ADD;
        dmem_wen     = 1'b0;
        instr_done   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                // rst_n qualifies the fetch strobes so nothing is written while reset is held
                if (run && rst_n) begin
                    dp.irwrite = 1'b1;
                    dp.pcwrite = 1'b1;
                    dp.pccen   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into aluout while dispatching
                dp.asel   = ALUA_PCC;
                dp.bsel   = ALUB_IMM;
                dp.immsel = IMM_B;
                case (opcode)
                    7'b0110011:             state_next = S_EXEC_R;
                    7'b0010011:             state_next = S_EXEC_I;
                    7'b0000011, 7'b0100011: state_next = S_MEM_ADDR;
                    7'b1100011:             state_next = S_BRANCH;
                    7'b1101111:             state_next = S_JAL;
                    7'b1100111:             state_next = S_JALR;
                    default:                state_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                dp.alusel  = f3_alu(funct3, alt);
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                // instr[30] is part of the immediate except for the shift-right pair
                dp.bsel    = ALUB_IMM;
                dp.alusel  = f3_alu(funct3, (funct3 == 3'b101) && alt);
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                dp.regwen  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                // opcode bit 5 distinguishes store (0100011) from load (0000011)
                dp.bsel    = ALUB_IMM;
                dp.immsel  = opcode[5] ? IMM_S : IMM_L;
                state_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                dp.mdrwrite = 1'b1;
                state_next  = S_MEM_WB;
            end
            S_MEM_WB: begin
                dp.regwen  = 1'b1;
                dp.wbsel   = WB_MDR;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                dmem_wen   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                // The PC loads the target captured in DECODE while the compare
                // result overwrites aluout on the same edge.
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    state_next = S_TRAP;
                end else begin
                    case (funct3)
                        3'b000:  begin dp.alusel = ALU_SUB;  dp.pcwrite = dp.zero;  end
                        3'b001:  begin dp.alusel = ALU_SUB;  dp.pcwrite = !dp.zero; end
                        3'b100:  begin dp.alusel = ALU_SLT;  dp.pcwrite = !dp.zero; end
                        3'b101:  begin dp.alusel = ALU_SLT;  dp.pcwrite = dp.zero;  end
                        3'b110:  begin dp.alusel = ALU_SLTU; dp.pcwrite = !dp.zero; end
                        default: begin dp.alusel = ALU_SLTU; dp.pcwrite = dp.zero;  end
                    endcase
                    dp.pcsourse = PC_ALU;
                    instr_done  = 1'b1;
                    state_next  = S_FETCH;
                end
            end
            S_JAL: begin
                dp.asel    = ALUA_PCC;
                dp.bsel    = ALUB_IMM;
                dp.immsel  = IMM_J;
                state_next = S_JUMP_WB;
            end
            S_JALR: begin
                dp.bsel    = ALUB_IMM;
                state_next = S_JUMP_WB;
            end
            S_JUMP_WB: begin
                dp.regwen   = 1'b1;
                dp.wbsel    = WB_PC;
                dp.pcwrite  = 1'b1;
                dp.pcsourse = PC_ALU;
                instr_done  = 1'b1;
                state_next  = S_FETCH;
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

`ifdef RV_CTL_PERF_EN
    logic [DPWIDTH-1:0] cycle_cnt_reg;
    logic [DPWIDTH-1:0] instret_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            // Idle FETCH cycles and the halted state do not count as executed
            if (state_reg != S_TRAP && !(state_reg == S_FETCH && !run))
                cycle_cnt_reg <= cycle_cnt_reg + DPWIDTH'(1);
            if (instr_done)
                instret_cnt_reg <= instret_cnt_reg + DPWIDTH'(1);
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_ctl.sv
module tb_rv_ctl;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
                           S_ALU_WB = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7,
                           S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
                           S_JUMP_WB = 4'd12, S_TRAP = 4'd13;
    localparam logic [1:0] IMM_L = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2, IMM_J = 2'd3;
    localparam logic [1:0] A_REG = 2'd0, A_PCC = 2'd1;
    localparam logic       B_REG = 1'b0, B_IMM = 1'b1;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2;
    localparam logic       PC_P4 = 1'b0, PC_ALU = 1'b1;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
                           ALU_SRA = 4'd7;
    // enable bits: {irwrite,pcwrite,pccen,regwen,mdrwrite,dmem_wen,instr_done,halt}
    localparam logic [7:0] E_IR = 8'h80, E_PCW = 8'h40, E_PCC = 8'h20, E_RW = 8'h10,
                           E_MDR = 8'h08, E_DW = 8'h04, E_DONE = 8'h02, E_HALT = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        dmem_wen, halt, instr_done;
    logic [3:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;

    rv_ctl_if #(.DPWIDTH(32)) dp_if ();

    rv_ctl #(.DPWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .dp(dp_if), .run(run), .dmem_wen(dmem_wen),
        .halt(halt), .instr_done(instr_done), .state(state),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [24:0] v;
        bit          inc;
        bit          done;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_ret = 0;

    function automatic logic [24:0] obs_vec();
        return {state, dp_if.irwrite, dp_if.pcwrite, dp_if.pccen, dp_if.regwen,
                dp_if.mdrwrite, dmem_wen, instr_done, halt, dp_if.pcsourse, dp_if.wbsel,
                dp_if.immsel, dp_if.asel, dp_if.bsel, dp_if.alusel, dp_if.bff};
    endfunction

    function automatic logic [24:0] mk(logic [3:0] st, logic [7:0] en, logic pcs,
                                       logic [1:0] wb, logic [1:0] imm, logic [1:0] as,
                                       logic bs, logic [3:0] alu);
        return {st, en, pcs, wb, imm, as, bs, alu, 1'b0};
    endfunction

    task automatic push(string tag, logic [3:0] st, logic [7:0] en, logic pcs,
                        logic [1:0] wb, logic [1:0] imm, logic [1:0] as, logic bs,
                        logic [3:0] alu);
        exp_t e;
        e.tag  = tag;
        e.v    = mk(st, en, pcs, wb, imm, as, bs, alu);
        e.inc  = (st != S_TRAP) && !(st == S_FETCH && en[7] == 1'b0);
        e.done = en[1];
        sb.push_back(e);
    endtask

    task automatic push_d(string tag, logic [3:0] st, logic [7:0] en);
        push(tag, st, en, PC_P4, WB_ALU, IMM_L, A_REG, B_REG, ALU_ADD);
    endtask

    task automatic push_fd();
        push_d("fetch", S_FETCH, E_IR | E_PCW | E_PCC);
        push("decode", S_DECODE, 8'h00, PC_P4, WB_ALU, IMM_B, A_PCC, B_IMM, ALU_ADD);
    endtask

    task automatic check_vec(string tag, logic [24:0] exp_v);
        logic [24:0] o;
        o = obs_vec();
        total_cnt++;
        assert (o === exp_v) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, exp_v);
    endtask

    task automatic check32(string tag, logic [31:0] o, logic [31:0] exp_v);
        total_cnt++;
        assert (o === exp_v) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, o, exp_v);
    endtask

    // Called at a negedge: compares one expected record per cycle, in order
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            #1;
            check_vec(e.tag, e.v);
            $display("cycle %-8s state=%0d vec=%h", e.tag, state, obs_vec());
            if (e.inc)  m_cyc++;
            if (e.done) m_ret++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk_cnt(string tag);
`ifdef RV_CTL_PERF_EN
        check32({tag, "_cyc"}, cycle_cnt, m_cyc);
        check32({tag, "_ret"}, instret_cnt, m_ret);
`else
        check32({tag, "_cyc"}, cycle_cnt, 32'd0);
        check32({tag, "_ret"}, instret_cnt, 32'd0);
`endif
    endtask

    // Assert reset between edges, verify the reset image, release on a negedge
    task automatic reset_pulse(string tag);
        rst_n = 1'b0;
        #1;
        check_vec({tag, "_rst"}, mk(S_FETCH, 8'h00, PC_P4, WB_ALU, IMM_L, A_REG, B_REG, ALU_ADD));
        check32({tag, "_rst_cyc"}, cycle_cnt, 32'd0);
        check32({tag, "_rst_ret"}, instret_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cyc = 0;
        m_ret = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        dp_if.instr = 32'h0;
        dp_if.zero = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("reset", mk(S_FETCH, 8'h00, PC_P4, WB_ALU, IMM_L, A_REG, B_REG, ALU_ADD));
        check32("reset_cyc", cycle_cnt, 32'd0);
        check32("reset_ret", instret_cnt, 32'd0);
        rst_n = 1'b1;
        run = 1'b1;

        // addi x1,x0,5
        dp_if.instr = 32'h00500093;
        push_fd();
        push("exec_i", S_EXEC_I, 8'h00, PC_P4, WB_ALU, IMM_L, A_REG, B_IMM, ALU_ADD);
        push_d("alu_wb", S_ALU_WB, E_RW | E_DONE);
        drain();
        chk_cnt("addi");

        // srai: instr[30] selects SRA for funct3=101
        dp_if.instr = 32'h4020D093;
        push_fd();
        push("exec_i", S_EXEC_I, 8'h00, PC_P4, WB_ALU, IMM_L, A_REG, B_IMM, ALU_SRA);
        push_d("alu_wb", S_ALU_WB, E_RW | E_DONE);
        drain();

        // sub x3,x1,x2
        dp_if.instr = 32'h402081B3;
        push_fd();
        push("exec_r", S_EXEC_R, 8'h00, PC_P4, WB_ALU, IMM_L, A_REG, B_REG, ALU_SUB);
        push_d("alu_wb", S_ALU_WB, E_RW | E_DONE);
        drain();

        // lw
        dp_if.instr = 32'h0000A103;
        push_fd();
        push("mem_addr", S_MEM_ADDR, 8'h00, PC_P4, WB_ALU, IMM_L, A_REG, B_IMM, ALU_ADD);
        push_d("mem_rd", S_MEM_RD, E_MDR);
        push("mem_wb", S_MEM_WB, E_RW | E_DONE, PC_P4, WB_MDR, IMM_L, A_REG, B_REG, ALU_ADD);
        drain();

        // sw
        dp_if.instr = 32'h00112023;
        push_fd();
        push("mem_addr", S_MEM_ADDR, 8'h00, PC_P4, WB_ALU, IMM_S, A_REG, B_IMM, ALU_ADD);
        push_d("mem_wr", S_MEM_WR, E_DW | E_DONE);
        drain();
        chk_cnt("mem");

        // beq taken / not taken
        dp_if.instr = 32'h00000463;
        dp_if.zero = 1'b1;
        push_fd();
        push("beq_t", S_BRANCH, E_PCW | E_DONE, PC_ALU, WB_ALU, IMM_L, A_REG, B_REG, ALU_SUB);
        drain();
        dp_if.zero = 1'b0;
        push_fd();
        push("beq_nt", S_BRANCH, E_DONE, PC_ALU, WB_ALU, IMM_L, A_REG, B_REG, ALU_SUB);
        drain();
        // bne taken with zero=0
        dp_if.instr = 32'h00001463;
        push_fd();
        push("bne_t", S_BRANCH, E_PCW | E_DONE, PC_ALU, WB_ALU, IMM_L, A_REG, B_REG, ALU_SUB);
        drain();
        // blt taken with zero=0
        dp_if.instr = 32'h00004463;
        push_fd();
        push("blt_t", S_BRANCH, E_PCW | E_DONE, PC_ALU, WB_ALU, IMM_L, A_REG, B_REG, ALU_SLT);
        drain();
        // bgeu taken with zero=1
        dp_if.instr = 32'h00007463;
        dp_if.zero = 1'b1;
        push_fd();
        push("bgeu_t", S_BRANCH, E_PCW | E_DONE, PC_ALU, WB_ALU, IMM_L, A_REG, B_REG, ALU_SLTU);
        drain();
        dp_if.zero = 1'b0;

        // jal, jalr
        dp_if.instr = 32'h008000EF;
        push_fd();
        push("jal", S_JAL, 8'h00, PC_P4, WB_ALU, IMM_J, A_PCC, B_IMM, ALU_ADD);
        push("jump_wb", S_JUMP_WB, E_RW | E_PCW | E_DONE, PC_ALU, WB_PC, IMM_L, A_REG, B_REG, ALU_ADD);
        drain();
        dp_if.instr = 32'h000080E7;
        push_fd();
        push("jalr", S_JALR, 8'h00, PC_P4, WB_ALU, IMM_L, A_REG, B_IMM, ALU_ADD);
        push("jump_wb", S_JUMP_WB, E_RW | E_PCW | E_DONE, PC_ALU, WB_PC, IMM_L, A_REG, B_REG, ALU_ADD);
        drain();
        chk_cnt("jumps");

        // run low for 3 cycles in FETCH
        run = 1'b0;
        repeat (3) push_d("idle", S_FETCH, 8'h00);
        drain();
        chk_cnt("idle");
        run = 1'b1;

        // reset pulse during MEM_RD
        dp_if.instr = 32'h0000A103;
        push_fd();
        push("mem_addr", S_MEM_ADDR, 8'h00, PC_P4, WB_ALU, IMM_L, A_REG, B_IMM, ALU_ADD);
        drain();
        #1;
        check_vec("pre_rst_mem_rd", mk(S_MEM_RD, E_MDR, PC_P4, WB_ALU, IMM_L, A_REG, B_REG, ALU_ADD));
        reset_pulse("mem_rd_abort");

        // illegal opcode: sticky halt across run toggles
        dp_if.instr = 32'h0000007F;
        push_fd();
        push_d("trap", S_TRAP, E_HALT);
        push_d("trap", S_TRAP, E_HALT);
        drain();
        run = 1'b0;
        push_d("trap_r0", S_TRAP, E_HALT);
        push_d("trap_r0", S_TRAP, E_HALT);
        drain();
        run = 1'b1;
        push_d("trap_r1", S_TRAP, E_HALT);
        drain();
        chk_cnt("trap");
        reset_pulse("trap_clear");

        // branch funct3=010 traps without a PC write
        dp_if.instr = 32'h00002463;
        push_fd();
        push_d("br_bad", S_BRANCH, 8'h00);
        push_d("trap", S_TRAP, E_HALT);
        drain();
        chk_cnt("br_trap");
        reset_pulse("br_clear");

        // addi after recovery runs normally
        dp_if.instr = 32'h00500093;
        push_fd();
        push("exec_i", S_EXEC_I, 8'h00, PC_P4, WB_ALU, IMM_L, A_REG, B_IMM, ALU_ADD);
        push_d("alu_wb", S_ALU_WB, E_RW | E_DONE);
        drain();
        chk_cnt("recover");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
